// File: rtl/uart_pkg.sv
// Shared defaults for the UART subsystem.
// The reset-default baud divisor is computed here.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DIV_WIDTH_DEF  = 16;
  localparam int unsigned FRAC_WIDTH_DEF = 4;

  // Integer clk cycles per rx tick; the fractional part is dropped.
  function automatic int unsigned default_div(input int unsigned clk_hz,
                                              input int unsigned baud,
                                              input int unsigned oversample);
    return clk_hz / (baud * oversample);
  endfunction

endpackage

// File: rtl/frac_tick_div.sv
// Integer+fractional clock divider that produces a one-cycle strobe.
// New divisors are shadowed and only take effect on a period boundary.
module frac_tick_div
  import uart_pkg::*;
#(
  parameter int unsigned            DIV_WIDTH  = DIV_WIDTH_DEF,
  parameter int unsigned            FRAC_WIDTH = FRAC_WIDTH_DEF,
  parameter logic [DIV_WIDTH-1:0]   RST_DIV    = DIV_WIDTH'(2)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DIV_WIDTH-1:0]  div_int,
  input  logic [FRAC_WIDTH-1:0] div_frac,
  input  logic                  div_load,
  output logic                  tick,
  output logic                  wrap,
  output logic                  err
);

  logic [DIV_WIDTH-1:0]  act_int, act_int_nxt, pend_int;
  logic [FRAC_WIDTH-1:0] act_frac, act_frac_nxt, pend_frac, acc;
  logic                  pend_vld, carry, run;
  logic [DIV_WIDTH:0]    cnt, period_m1;
  logic [FRAC_WIDTH:0]   acc_sum;

  assign run       = en && !err;
  assign period_m1 = {1'b0, act_int} + (DIV_WIDTH+1)'(carry) - (DIV_WIDTH+1)'(1);
  assign wrap      = run && (cnt == period_m1);
  assign acc_sum   = {1'b0, acc} + {1'b0, act_frac_nxt};

  // A load while idle or on a wrap is applied at once; otherwise the pending copy waits for the wrap.
  always_comb begin
    act_int_nxt  = act_int;
    act_frac_nxt = act_frac;
    if (div_load && (!run || wrap)) begin
      act_int_nxt  = div_int;
      act_frac_nxt = div_frac;
    end else if (wrap && pend_vld) begin
      act_int_nxt  = pend_int;
      act_frac_nxt = pend_frac;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_int   <= RST_DIV;
      act_frac  <= '0;
      pend_int  <= RST_DIV;
      pend_frac <= '0;
      pend_vld  <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      tick      <= 1'b0;
      err       <= 1'b0;
    end else begin
      act_int  <= act_int_nxt;
      act_frac <= act_frac_nxt;
      err      <= (act_int_nxt < DIV_WIDTH'(2));
      tick     <= wrap;

      if (div_load && run && !wrap) begin
        pend_int  <= div_int;
        pend_frac <= div_frac;
        pend_vld  <= 1'b1;
      end else if (div_load || wrap) begin
        pend_vld  <= 1'b0;
      end

      if (!run) begin
        cnt   <= '0;
        acc   <= '0;
        carry <= 1'b0;
      end else if (wrap) begin
        cnt          <= '0;
        {carry, acc} <= acc_sum;
      end else begin
        cnt <= cnt + (DIV_WIDTH+1)'(1);
      end
    end
  end

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Fractional UART baud generator: rx_tick at OVERSAMPLE x baud, tx_tick at baud,
// with tx_tick coincident with every OVERSAMPLE-th rx_tick.
module uart_baud_gen_frac
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100000000,
  parameter int unsigned DEFAULT_BAUD = 9600,
  parameter int unsigned OVERSAMPLE   = OVERSAMPLE_DEF,
  parameter int unsigned DIV_WIDTH    = DIV_WIDTH_DEF,
  parameter int unsigned FRAC_WIDTH   = FRAC_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DIV_WIDTH-1:0]  div_int,
  input  logic [FRAC_WIDTH-1:0] div_frac,
  input  logic                  div_load,
  output logic                  rx_tick,
  output logic                  tx_tick,
  output logic                  cfg_err
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [DIV_WIDTH-1:0] RST_DIV =
    DIV_WIDTH'(default_div(CLK_HZ, DEFAULT_BAUD, OVERSAMPLE));

  logic            wrap, div_tick, div_err;
  logic [OS_W-1:0] os_cnt;

  frac_tick_div #(
    .DIV_WIDTH  (DIV_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH),
    .RST_DIV    (RST_DIV)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_int  (div_int),
    .div_frac (div_frac),
    .div_load (div_load),
    .tick     (div_tick),
    .wrap     (wrap),
    .err      (div_err)
  );

  // tx_tick is registered off the same wrap as rx_tick so the two line up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_cnt  <= '0;
      tx_tick <= 1'b0;
    end else begin
      tx_tick <= wrap && (os_cnt == OS_LAST);
      if (!en || div_err)
        os_cnt <= '0;
      else if (wrap)
        os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
    end
  end

  assign rx_tick = div_tick;
  assign cfg_err = div_err;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Directed bench for uart_baud_gen_frac at 100 MHz / 9600 baud / x16.
module tb_uart_baud_gen_frac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        div_load;
  logic        rx_tick, tx_tick, cfg_err;

  int checks = 0;
  int errors = 0;

  uart_baud_gen_frac #(
    .CLK_HZ       (100000000),
    .DEFAULT_BAUD (9600),
    .OVERSAMPLE   (16),
    .DIV_WIDTH    (16),
    .FRAC_WIDTH   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_int  (div_int),
    .div_frac (div_frac),
    .div_load (div_load),
    .rx_tick  (rx_tick),
    .tx_tick  (tx_tick),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  // Negedges until rx_tick is seen, bounded.
  task automatic wait_rx(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rx_tick && n < 2000);
  endtask

  // Stop, load a divisor while idle (applies at once), then run.
  task automatic restart(input int di, input int df);
    @(negedge clk); en = 1'b0;
    @(negedge clk); div_int = di[15:0]; div_frac = df[3:0]; div_load = 1'b1;
    @(negedge clk); div_load = 1'b0; en = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; div_load = 1'b0; div_int = '0; div_frac = '0;
    repeat (3) @(negedge clk);
    checks++; if (rx_tick !== 1'b0) begin errors++; $display("FAIL reset_rx got %b exp 0", rx_tick); end
    checks++; if (tx_tick !== 1'b0) begin errors++; $display("FAIL reset_tx got %b exp 0", tx_tick); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", cfg_err); end
  endtask

  task automatic test_default;
    int rx_cnt = 0, rx1 = 0, rx2 = 0, tx_cnt = 0, tx1 = 0, tx2 = 0, bad = 0;
    rst_n = 1'b1; en = 1'b1;
    for (int k = 1; k <= 21000; k++) begin
      @(negedge clk);
      if (rx_tick) begin
        rx_cnt++;
        if (rx_cnt == 1) rx1 = k;
        if (rx_cnt == 2) rx2 = k;
      end
      if (tx_tick) begin
        tx_cnt++;
        if (tx_cnt == 1) tx1 = k;
        else if (tx_cnt == 2) tx2 = k;
        if (!rx_tick || (rx_cnt % 16) != 0) bad++;
      end
    end
    checks++; if (rx1 !== 651) begin errors++; $display("FAIL def_first_rx got %0d exp 651", rx1); end
    checks++; if (rx2 - rx1 !== 651) begin errors++; $display("FAIL def_rx_period got %0d exp 651", rx2 - rx1); end
    checks++; if (rx_cnt !== 32) begin errors++; $display("FAIL def_rx_count got %0d exp 32", rx_cnt); end
    checks++; if (tx1 !== 10416) begin errors++; $display("FAIL def_first_tx got %0d exp 10416", tx1); end
    checks++; if (tx2 - tx1 !== 10416) begin errors++; $display("FAIL def_tx_period got %0d exp 10416", tx2 - tx1); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL def_tx_align got %0d exp 0", bad); end
  endtask

  task automatic test_div4;
    int rx_cnt = 0, prev = 0, gap_bad = 0, tx_cnt = 0, tx1 = 0, tx2 = 0, bad = 0;
    restart(4, 0);
    for (int k = 1; k <= 140; k++) begin
      @(negedge clk);
      if (rx_tick) begin
        rx_cnt++;
        if (k - prev != 4) gap_bad++;
        prev = k;
      end
      if (tx_tick) begin
        tx_cnt++;
        if (tx_cnt == 1) tx1 = k;
        else if (tx_cnt == 2) tx2 = k;
        if (!rx_tick) bad++;
      end
    end
    checks++; if (rx_cnt !== 35) begin errors++; $display("FAIL div4_rx_count got %0d exp 35", rx_cnt); end
    checks++; if (gap_bad !== 0) begin errors++; $display("FAIL div4_rx_gap got %0d bad exp 0", gap_bad); end
    checks++; if (tx1 !== 64) begin errors++; $display("FAIL div4_first_tx got %0d exp 64", tx1); end
    checks++; if (tx2 - tx1 !== 64) begin errors++; $display("FAIL div4_tx_period got %0d exp 64", tx2 - tx1); end
    checks++; if (bad !== 0 || tx_cnt !== 2) begin errors++; $display("FAIL div4_tx_align got %0d/%0d exp 0/2", bad, tx_cnt); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL div4_err got %b exp 0", cfg_err); end
  endtask

  task automatic test_frac;
    int n1, n2, n3, n, sum = 0;
    restart(4, 8);
    wait_rx(n1); wait_rx(n2); wait_rx(n3);
    checks++; if (n1 !== 4 || n2 !== 4 || n3 !== 5) begin errors++; $display("FAIL frac_first_gaps got %0d,%0d,%0d exp 4,4,5", n1, n2, n3); end
    for (int i = 0; i < 32; i++) begin
      wait_rx(n);
      sum += n;
    end
    checks++; if (sum !== 144) begin errors++; $display("FAIL frac_span32 got %0d exp 144", sum); end
  endtask

  task automatic test_midload;
    int n, m, g1, g2;
    restart(4, 0);
    wait_rx(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL mid_first got %0d exp 4", n); end
    @(negedge clk); div_int = 16'd7;  div_load = 1'b1;
    @(negedge clk); div_int = 16'd10; div_load = 1'b1;
    @(negedge clk); div_load = 1'b0;
    wait_rx(m);
    checks++; if (3 + m !== 4) begin errors++; $display("FAIL mid_cur_period got %0d exp 4", 3 + m); end
    wait_rx(g1); wait_rx(g2);
    checks++; if (g1 !== 10 || g2 !== 10) begin errors++; $display("FAIL mid_new_period got %0d,%0d exp 10,10", g1, g2); end
    // Load lands on the wrap edge itself.
    repeat (9) @(negedge clk);
    div_int = 16'd5; div_load = 1'b1;
    @(negedge clk); div_load = 1'b0;
    checks++; if (rx_tick !== 1'b1) begin errors++; $display("FAIL wrapload_tick got %b exp 1", rx_tick); end
    wait_rx(g1); wait_rx(g2);
    checks++; if (g1 !== 5 || g2 !== 5) begin errors++; $display("FAIL wrapload_period got %0d,%0d exp 5,5", g1, g2); end
  endtask

  task automatic test_cfg_err;
    int n, cnt = 0, g1, g2;
    @(negedge clk); div_int = 16'd1; div_load = 1'b1;
    @(negedge clk); div_load = 1'b0;
    wait_rx(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL err_last_tick got %0d exp 3", n); end
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", cfg_err); end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rx_tick || tx_tick) cnt++;
    end
    checks++; if (cnt !== 0 || cfg_err !== 1'b1) begin errors++; $display("FAIL err_quiet got %0d ticks err %b exp 0 ticks err 1", cnt, cfg_err); end
    div_int = 16'd3; div_load = 1'b1;
    @(negedge clk); div_load = 1'b0;
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", cfg_err); end
    wait_rx(g1); wait_rx(g2);
    checks++; if (g1 !== 3 || g2 !== 3) begin errors++; $display("FAIL err_recover got %0d,%0d exp 3,3", g1, g2); end
  endtask

  task automatic test_reset_mid;
    int n;
    wait_rx(n);
    #1 rst_n = 1'b0; en = 1'b0;
    #1;
    checks++; if (rx_tick !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("FAIL rstmid_async got rx %b err %b exp 0 0", rx_tick, cfg_err); end
    repeat (5) @(negedge clk);
    rst_n = 1'b1; en = 1'b1;
    wait_rx(n);
    checks++; if (n !== 651) begin errors++; $display("FAIL rstmid_first got %0d exp 651", n); end
    // Pending divisor must be discarded by reset.
    @(negedge clk); div_int = 16'd20; div_load = 1'b1;
    @(negedge clk); div_load = 1'b0; rst_n = 1'b0; en = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1; en = 1'b1;
    wait_rx(n);
    checks++; if (n !== 651) begin errors++; $display("FAIL rstmid_discard got %0d exp 651", n); end
  endtask

  initial begin
    test_reset;
    test_default;
    test_div4;
    test_frac;
    test_midload;
    test_cfg_err;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_baud_gen_frac.md
Name: uart_baud_gen_frac

Overview:
Next-generation UART baud generator for the UART subsystem: runtime-programmable fractional divisor, configurable oversampling ratio, single-cycle tick strobes instead of toggling clocks. Produces rx_tick at OVERSAMPLE x baud and tx_tick at baud, phase-locked to each other (tx_tick coincides with every OVERSAMPLE-th rx_tick). Sits between the register block (divisor source) and the UART tx/rx FSMs (tick consumers).

Parameters:
CLK_HZ, 100000000, system clock frequency; used only for reset-default divisor.
DEFAULT_BAUD, 9600, baud rate selected out of reset.
OVERSAMPLE, 16, rx ticks per bit period; legal 4..32.
DIV_WIDTH, 16, width of integer divisor.
FRAC_WIDTH, 4, width of fractional divisor (units of 1/2^FRAC_WIDTH).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  run enable; 0 clears counters and holds ticks low.
div_int  input  DIV_WIDTH  integer part of clk cycles per rx tick.
div_frac  input  FRAC_WIDTH  fractional part of clk cycles per rx tick.
div_load  input  1  single-cycle strobe: capture div_int/div_frac.
rx_tick  output  1  one-cycle strobe at OVERSAMPLE x baud.
tx_tick  output  1  one-cycle strobe at baud.
cfg_err  output  1  active divisor illegal (div_int < 2); ticks suppressed.

Behaviour:
- Reset: active divisor = CLK_HZ/(DEFAULT_BAUD*OVERSAMPLE) integer part, frac = 0; pending divisor = same; div counter, frac accumulator, oversample counter = 0; rx_tick = tx_tick = cfg_err = 0. All outputs registered.
- Div counter counts 0..P-1, P = div_int_active + carry. On the cycle counter reaches P-1 it wraps to 0 and rx_tick is high the following cycle (exactly 1 clk).
- Fractional: at each wrap, {carry, acc} <= acc + div_frac_active (FRAC_WIDTH+1 bit add); carry extends the NEXT period by one clk. Long-run mean period = div_int + div_frac/2^FRAC_WIDTH.
- Oversample counter increments on each rx tick event, 0..OVERSAMPLE-1; at wrap tx_tick is high in the same cycle as rx_tick.
- First rx_tick after en rises (or after reset release with en=1): P cycles after the counter starts, i.e. rx_tick high in cycle P+1 counting the en-rise edge as cycle 1... precisely: counter starts at 0 on first enabled edge; first rx_tick asserted after the P-th enabled edge.
- en=0: div counter, accumulator, oversample counter cleared synchronously; ticks forced 0; active divisor retained; div_load still accepted and applied immediately (next cycle).
- div_load with en=1: value stored as pending; becomes active at the next div-counter wrap (glitch-free, no truncated period). Oversample counter and accumulator not cleared. Second div_load before application overwrites pending (last wins).
- div_load on the same cycle as a wrap: new value governs the very next period.
- cfg_err = (div_int_active < 2); while set counters held at 0, ticks 0; clears when a legal divisor becomes active.
- Reset asserted mid-operation: immediate return to reset state, including discarding pending divisor.
- Counter width DIV_WIDTH+1 to hold div_int+carry with no overflow at div_int = 2^DIV_WIDTH-1.

Decomposition:
- Package uart_pkg: OVERSAMPLE default constant, function computing default divisor from CLK_HZ/baud/oversample, DIV_WIDTH/FRAC_WIDTH defaults.
- One sub-module: frac_tick_div (integer+fractional counter producing a one-cycle strobe, with pending/active divisor shadowing); top adds oversample counter, tx_tick, cfg_err.

Test Plan:
- Reset release, en=1, CLK_HZ=100e6, DEFAULT_BAUD=9600, OVERSAMPLE=16 -> rx_tick every 651 clks, tx_tick every 10416 clks, coincident with every 16th rx_tick.
- div_load div_int=4, div_frac=0 -> rx_tick period exactly 4 clks, tx_tick period 64 clks; cfg_err=0.
- div_int=4, div_frac=8 (FRAC_WIDTH=4) -> rx periods alternate 4,5; 32 rx_ticks span 144 clks.
- div_load div_int=10 midway through a div_int=4 period -> current period completes at 4, following periods 10; no short/double tick.
- div_load div_int=1 -> cfg_err=1 and no ticks for 100 clks; then div_int=3 -> cfg_err=0, rx_tick every 3 clks.
- Assert rst_n=0 mid-period and en=0 for 5 clks -> ticks 0 immediately; after release first rx_tick arrives exactly one full period later.
